simd_alu_pipe: RTL
==================

Name: simd_alu_pipe

Overview:
- Parametrised, pipelined successor to the single-stage SIMD ALU.
- Lane-parallel add/sub (unsigned and signed), logical shifts and arithmetic right shift over DATA_WIDTH-bit vectors.
- Runtime lane size: 8/16/32/64 bits.
- Two-stage pipeline with valid/ready handshake and full backpressure. Sits between the vector register read port and the writeback arbiter.

Parameters:
- DATA_WIDTH, 256, vector width in bits; multiple of 64, minimum 64.
- FLAG_WIDTH, DATA_WIDTH/8, derived; one flag bit per byte position.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  DATA_WIDTH  operand A.
- in_b  in  DATA_WIDTH  operand B, or per-lane shift amount.
- in_op  in  3  0 ADD, 1 SUB, 2 S_ADD, 3 S_SUB, 4 LSL, 5 LSR, 6 ASR, 7 reserved.
- in_mode  in  2  lane size: 0 = 8, 1 = 16, 2 = 32, 3 = 64.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_WIDTH  lane results.
- out_overflow  out  FLAG_WIDTH  per-lane overflow.
- out_underflow  out  FLAG_WIDTH  per-lane underflow.

Behaviour:
- Reset (async assert, sync release): s1_valid = 0, s2_valid = 0, out_data = 0, out_overflow = 0, out_underflow = 0.
- in_ready is 1 out of reset.
- Stage 1 registers in_a, in_b, in_op, in_mode on acceptance (in_valid & in_ready).
- Stage 2 computes and registers out_data and the flags.
- Latency: result visible 2 cycles after acceptance, with no stall.
- Advance rules:
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
- Throughput: one beat per cycle while out_ready = 1.
- Outputs hold stable while out_valid & ~out_ready.
- out_valid drops only after a handshake with no new beat behind it.
- Lanes: N = DATA_WIDTH / (8 << in_mode). Lane k occupies bits [k*L +: L].
- ADD/SUB, unsigned:
  - out_overflow set on carry-out of ADD.
  - out_underflow set on borrow of SUB (a < b).
- S_ADD/S_SUB, two's complement:
  - out_overflow set when the true result > max signed.
  - out_underflow set when the true result < min signed.
- Flag placement: a lane's flag sits on the bit of its most significant byte (index k*L/8 + L/8 - 1). All other flag bits are 0.
- Shifts:
  - Amount = low log2(L) bits of the corresponding b lane; upper bits ignored.
  - LSL/LSR fill with zeros; ASR fills with the lane sign.
  - Flags are 0.
- Reserved op: out_data = 0, flags = 0, beat still flows and handshakes.
- Simultaneous accept and drain with the pipe full: both stages advance the same cycle; no bubble.
- Reset mid-operation: in-flight beats are discarded, nothing is emitted. The first beat after reset appears 2 cycles after its acceptance.

Optional Feature:
- Macro: SIMD_ALU_SAT_EN.
- Defined: ADD/SUB/S_ADD/S_SUB saturate.
  - Unsigned ADD overflow yields all-ones; unsigned SUB underflow yields 0.
  - Signed results clamp to max/min signed.
  - Flags are unchanged (they report that the clamp occurred).
- Undefined: results wrap modulo 2^L; flags identical.
- Shifts are unaffected either way.

Decomposition:
- Package simd_alu_pkg holds:
  - in_op enum type and its values.
  - Lane-mode enum (MODE_8, MODE_16, MODE_32, MODE_64).
  - Constant SIMD_ALU_LANE_MAX = 64.
  - Function lane_bits(mode).
- One sub-module, simd_alu_lane64: purely combinational, handles a 64-bit slice in all four modes (one 64-bit lane, or 2/4/8 sub-lanes), with its own 8-bit flag slices.
  - The top instantiates DATA_WIDTH/64 copies, plus the two pipeline register stages and the handshake.

Test Plan:
- Reset and latency: assert rst for 3 cycles, release, then one beat ADD mode 0 with a = 0x01 per byte, b = 0x02 per byte, out_ready = 1.
  - Expect every byte = 0x03, flags 0, out_valid exactly 2 cycles after acceptance.
- Unsigned ADD mode 1, lane a = 0xFFFF, b = 0x0001:
  - wrap: result 0x0000, overflow bit at the lane's upper byte = 1.
  - SIMD_ALU_SAT_EN: result 0xFFFF, same flag.
- S_SUB mode 0, a = 0x80, b = 0x01:
  - underflow = 1.
  - wrap: result 0x7F; SIMD_ALU_SAT_EN: result 0x80.
  - S_ADD a = 0x7F, b = 0x01: overflow = 1, result 0x80 (wrap) / 0x7F (sat).
- Shifts, mode 3, a = 0x8000_0000_0000_0001, b lane = 0x41 (amount 1):
  - LSL gives 0x0000_0000_0000_0002.
  - LSR gives 0x4000_0000_0000_0000.
  - ASR gives 0xC000_0000_0000_0000.
- Backpressure: stream 10 beats with in_valid = 1 continuously and out_ready toggling 1,0,0,1,…
  - All 10 results in order, none lost or duplicated.
  - Outputs stable while stalled.
  - in_ready = 0 exactly when both stages are full and out_ready = 0.
- Mid-flight reset: accept 2 beats, pulse rst for 1 cycle before either emerges.
  - No out_valid until new input.
  - The next beat's result emerges 2 cycles after its acceptance.

Source files
------------

// File: rtl/simd_alu_pkg.sv
// Shared types and constants for the pipelined SIMD ALU.
// Saturation is selected at build time with SIMD_ALU_SAT_EN.
package simd_alu_pkg;

  localparam int unsigned SIMD_ALU_LANE_MAX = 64;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_S_ADD = 3'd2,
    OP_S_SUB = 3'd3,
    OP_LSL   = 3'd4,
    OP_LSR   = 3'd5,
    OP_ASR   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    MODE_8  = 2'd0,
    MODE_16 = 2'd1,
    MODE_32 = 2'd2,
    MODE_64 = 2'd3
  } mode_e;

  // Per-beat control captured alongside the operands in stage 1
  typedef struct packed {
    op_e   op;
    mode_e mode;
  } ctrl_t;

  function automatic int unsigned lane_bits(input mode_e mode);
    return 32'd8 << mode;
  endfunction

endpackage

// File: rtl/simd_alu_lane64.sv
// Combinational ALU for one 64-bit slice: one 64-bit lane or 2/4/8 sub-lanes.
// SIMD_ALU_SAT_EN makes add/sub results clamp instead of wrap.
module simd_alu_lane64
  import simd_alu_pkg::*;
(
  input  logic [SIMD_ALU_LANE_MAX-1:0] a,
  input  logic [SIMD_ALU_LANE_MAX-1:0] b,
  input  op_e                          op,
  input  mode_e                        mode,
  output logic [SIMD_ALU_LANE_MAX-1:0] res_c,
  output logic [7:0]                   ovf_c,
  output logic [7:0]                   unf_c
);

  logic [3:0][SIMD_ALU_LANE_MAX-1:0] res_m;
  logic [3:0][7:0]                   ovf_m;
  logic [3:0][7:0]                   unf_m;

  // Every lane size is computed in parallel; the runtime mode picks one
  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int unsigned LW = lane_bits(mode_e'(2'(m)));
    localparam int unsigned FB = LW / 8;
    localparam int unsigned SW = $clog2(LW);
    localparam int unsigned NL = SIMD_ALU_LANE_MAX / LW;
`ifdef SIMD_ALU_SAT_EN
    localparam logic [LW-1:0] SMAX = {1'b0, {(LW-1){1'b1}}};
    localparam logic [LW-1:0] SMIN = {1'b1, {(LW-1){1'b0}}};
`endif

    for (genvar k = 0; k < NL; k++) begin : g_lane
      logic [LW-1:0] la;
      logic [LW-1:0] lb;
      logic [LW-1:0] r;
      logic [LW:0]   sum;
      logic [LW:0]   diff;
      logic [SW-1:0] amt;
      logic          ovf_l;
      logic          unf_l;

      assign la   = a[k*LW +: LW];
      assign lb   = b[k*LW +: LW];
      assign sum  = {1'b0, la} + {1'b0, lb};
      assign diff = {1'b0, la} - {1'b0, lb};
      assign amt  = lb[SW-1:0];

      always_comb begin
        r     = '0;
        ovf_l = 1'b0;
        unf_l = 1'b0;
        case (op)
          OP_ADD: begin
            r     = sum[LW-1:0];
            ovf_l = sum[LW];
          end
          OP_SUB: begin
            r     = diff[LW-1:0];
            unf_l = diff[LW];
          end
          OP_S_ADD: begin
            r     = sum[LW-1:0];
            ovf_l = ~la[LW-1] & ~lb[LW-1] &  sum[LW-1];
            unf_l =  la[LW-1] &  lb[LW-1] & ~sum[LW-1];
          end
          OP_S_SUB: begin
            r     = diff[LW-1:0];
            ovf_l = ~la[LW-1] &  lb[LW-1] &  diff[LW-1];
            unf_l =  la[LW-1] & ~lb[LW-1] & ~diff[LW-1];
          end
          OP_LSL:  r = la << amt;
          OP_LSR:  r = la >> amt;
          OP_ASR:  r = LW'($signed(la) >>> amt);
          default: r = '0;
        endcase
`ifdef SIMD_ALU_SAT_EN
        // Unsigned ops clamp to their range ends; remaining flags come from signed ops
        if (op == OP_ADD && ovf_l) begin
          r = '1;
        end else if (op == OP_SUB && unf_l) begin
          r = '0;
        end else if (ovf_l) begin
          r = SMAX;
        end else if (unf_l) begin
          r = SMIN;
        end
`endif
      end

      // Flag lands on the lane's most significant byte position
      assign res_m[m][k*LW +: LW] = r;
      assign ovf_m[m][k*FB +: FB] = FB'(ovf_l) << (FB - 1);
      assign unf_m[m][k*FB +: FB] = FB'(unf_l) << (FB - 1);
    end
  end

  assign res_c = res_m[mode];
  assign ovf_c = ovf_m[mode];
  assign unf_c = unf_m[mode];

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage SIMD add/sub/shift ALU with valid/ready flow control and full backpressure.
// Build with SIMD_ALU_SAT_EN defined for saturating add/sub.
module simd_alu_pipe
  import simd_alu_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 256,
  localparam int unsigned FLAG_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [2:0]            in_op,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [FLAG_WIDTH-1:0] out_overflow,
  output logic [FLAG_WIDTH-1:0] out_underflow
);

  localparam int unsigned NSLICE = DATA_WIDTH / SIMD_ALU_LANE_MAX;
  localparam int unsigned SFW    = SIMD_ALU_LANE_MAX / 8;

  if (DATA_WIDTH < SIMD_ALU_LANE_MAX || (DATA_WIDTH % SIMD_ALU_LANE_MAX) != 0) begin : g_bad_width
    $error("simd_alu_pipe: DATA_WIDTH must be a non-zero multiple of 64");
  end

  logic                  s1_valid;
  logic                  s2_valid;
  logic                  s1_adv;
  logic                  s2_adv;
  logic                  accept;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  ctrl_t                 s1_ctrl;
  logic [DATA_WIDTH-1:0] res_c;
  logic [FLAG_WIDTH-1:0] ovf_c;
  logic [FLAG_WIDTH-1:0] unf_c;

  // A stage moves when it is empty or its successor frees up this cycle
  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign accept    = in_valid & s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_ctrl  <= '{op: OP_ADD, mode: MODE_8};
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_ctrl <= '{op: op_e'(in_op), mode: mode_e'(in_mode)};
      end
    end
  end

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    simd_alu_lane64 u_lane (
      .a     (s1_a[i*SIMD_ALU_LANE_MAX +: SIMD_ALU_LANE_MAX]),
      .b     (s1_b[i*SIMD_ALU_LANE_MAX +: SIMD_ALU_LANE_MAX]),
      .op    (s1_ctrl.op),
      .mode  (s1_ctrl.mode),
      .res_c (res_c[i*SIMD_ALU_LANE_MAX +: SIMD_ALU_LANE_MAX]),
      .ovf_c (ovf_c[i*SFW +: SFW]),
      .unf_c (unf_c[i*SFW +: SFW])
    );
  end

  // Result register only loads on a real beat so stalled outputs stay put
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid      <= 1'b0;
      out_data      <= '0;
      out_overflow  <= '0;
      out_underflow <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data      <= res_c;
        out_overflow  <= ovf_c;
        out_underflow <= unf_c;
      end
    end
  end

endmodule
